// File: rtl/ssd_frame_sequencer_if.sv
// ssd_frame_sequencer_if
//   Groups the signals between the lock/keypad logic, the VGA controller and
//   the frame sequencer. clk/rst are not part of this bundle.
//   master : drives vs, digit_val, digit_cnt, mask, evt_open, evt_err and
//            observes ssd_lines, msg_busy (keypad/lock side, or a testbench)
//   slave  : the sequencer itself
interface ssd_frame_sequencer_if;
  logic        vs;
  logic [15:0] digit_val;
  logic [2:0]  digit_cnt;
  logic        mask;
  logic        evt_open;
  logic        evt_err;
  logic [27:0] ssd_lines;
  logic        msg_busy;

  modport master (
    output vs, digit_val, digit_cnt, mask, evt_open, evt_err,
    input  ssd_lines, msg_busy
  );

  modport slave (
    input  vs, digit_val, digit_cnt, mask, evt_open, evt_err,
    output ssd_lines, msg_busy
  );
endinterface

// File: rtl/ssd_frame_sequencer.sv
// ssd_frame_sequencer
//   Builds the 28-bit active-low seven-segment vector for vga_display. The
//   four digits show either live keypad entry (hex or masked, with a blinking
//   cursor) or a timed status message (OPEn / Err). The output vector only
//   changes on a VGA frame boundary so no frame shows a half-updated glyph.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - slave modport of ssd_frame_sequencer_if:
//          vs (active-low frame sync), digit_val, digit_cnt, mask,
//          evt_open / evt_err (1-clk pulses), ssd_lines, msg_busy
module ssd_frame_sequencer #(
  parameter int MSG_FRAMES   = 120,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  ssd_frame_sequencer_if.slave bus
);

  localparam int RemainW = $clog2(MSG_FRAMES + 1);
  localparam int BlinkW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [RemainW-1:0] MsgLoad   = RemainW'(MSG_FRAMES);
  localparam logic [BlinkW-1:0]  BlinkLast = BlinkW'(BLINK_FRAMES - 1);

  localparam logic [6:0] GlyphO     = 7'b0000001;
  localparam logic [6:0] GlyphP     = 7'b0011000;
  localparam logic [6:0] GlyphE     = 7'b0110000;
  localparam logic [6:0] GlyphN     = 7'b1101010;
  localparam logic [6:0] GlyphR     = 7'b1111010;
  localparam logic [6:0] GlyphDash  = 7'b1111110;
  localparam logic [6:0] GlyphUnder = 7'b1110111;
  localparam logic [6:0] GlyphBlank = 7'b1111111;

  typedef enum logic [1:0] {
    ST_ENTRY,
    ST_MSG_OPEN,
    ST_MSG_ERR
  } state_e;

  // Active-low ABCDEFG pattern for a hex nibble
  function automatic logic [6:0] hexGlyph(input logic [3:0] nib);
    case (nib)
      4'h0: hexGlyph = 7'b0000001;
      4'h1: hexGlyph = 7'b1001111;
      4'h2: hexGlyph = 7'b0010010;
      4'h3: hexGlyph = 7'b0000110;
      4'h4: hexGlyph = 7'b1001100;
      4'h5: hexGlyph = 7'b0100100;
      4'h6: hexGlyph = 7'b0100000;
      4'h7: hexGlyph = 7'b0001111;
      4'h8: hexGlyph = 7'b0000000;
      4'h9: hexGlyph = 7'b0000100;
      4'hA: hexGlyph = 7'b0001000;
      4'hB: hexGlyph = 7'b1100000;
      4'hC: hexGlyph = 7'b0110001;
      4'hD: hexGlyph = 7'b1000010;
      4'hE: hexGlyph = 7'b0110000;
      default: hexGlyph = 7'b0111000;
    endcase
  endfunction

  logic               vsMeta_q, vsSync_q, vsLast_q, frameTick_q;
  logic               pendOpen_q, pendOpen_d;
  logic               pendErr_q, pendErr_d;
  state_e             state_q, state_d;
  logic [RemainW-1:0] remain_q, remain_d;
  logic [BlinkW-1:0]  blinkCnt_q, blinkCnt_d;
  logic               blinkOn_q, blinkOn_d;
  logic [27:0]        ssdLines_q, ssdLines_d;
  logic               msgBusy_q, msgBusy_d;
  logic [2:0]         effCnt;
  logic [27:0]        entryLines;
  logic [27:0]        frameLines;

  // Event flags are sticky until a tick consumes them; a pulse landing on the
  // consuming clk itself survives into the following frame.
  always_comb begin
    pendOpen_d = frameTick_q ? bus.evt_open : (pendOpen_q | bus.evt_open);
    pendErr_d  = frameTick_q ? bus.evt_err  : (pendErr_q  | bus.evt_err);
  end

  // Display mode and message countdown; ERR outranks OPEN, and a fresh event
  // during a message restarts the full hold time.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    if (frameTick_q) begin
      if (pendErr_q) begin
        state_d  = ST_MSG_ERR;
        remain_d = MsgLoad;
      end else if (pendOpen_q) begin
        state_d  = ST_MSG_OPEN;
        remain_d = MsgLoad;
      end else if (state_q != ST_ENTRY) begin
        if (remain_q == RemainW'(1)) begin
          state_d  = ST_ENTRY;
          remain_d = '0;
        end else begin
          remain_d = remain_q - RemainW'(1);
        end
      end
    end
  end

  // Free-running cursor blink, counted in frames
  always_comb begin
    blinkCnt_d = blinkCnt_q;
    blinkOn_d  = blinkOn_q;
    if (frameTick_q) begin
      if (blinkCnt_q == BlinkLast) begin
        blinkCnt_d = '0;
        blinkOn_d  = ~blinkOn_q;
      end else begin
        blinkCnt_d = blinkCnt_q + BlinkW'(1);
      end
    end
  end

  // Entry view: entered digits, then the cursor slot, then blanks. Uses the
  // post-tick blink phase so the cursor flips on the same frame as the wrap.
  always_comb begin
    entryLines = '1;
    effCnt     = (bus.digit_cnt > 3'd4) ? 3'd4 : bus.digit_cnt;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < effCnt) begin
        entryLines[27-7*i -: 7] = bus.mask ? GlyphDash
                                           : hexGlyph(bus.digit_val[15-4*i -: 4]);
      end else if (3'(i) == effCnt) begin
        entryLines[27-7*i -: 7] = blinkOn_d ? GlyphUnder : GlyphBlank;
      end
    end
  end

  // Pick the frame's content from the post-transition mode and only let it
  // through on a frame boundary.
  always_comb begin
    case (state_d)
      ST_MSG_OPEN: frameLines = {GlyphO, GlyphP, GlyphE, GlyphN};
      ST_MSG_ERR:  frameLines = {GlyphE, GlyphR, GlyphR, GlyphBlank};
      default:     frameLines = entryLines;
    endcase
    ssdLines_d = frameTick_q ? frameLines : ssdLines_q;
    msgBusy_d  = frameTick_q ? (state_d != ST_ENTRY) : msgBusy_q;
  end

  // All state: vs synchronizer (idles high), registered falling-edge tick,
  // pending flags, mode, counters and the committed outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsMeta_q    <= 1'b1;
      vsSync_q    <= 1'b1;
      vsLast_q    <= 1'b1;
      frameTick_q <= 1'b0;
      pendOpen_q  <= 1'b0;
      pendErr_q   <= 1'b0;
      state_q     <= ST_ENTRY;
      remain_q    <= '0;
      blinkCnt_q  <= '0;
      blinkOn_q   <= 1'b1;
      ssdLines_q  <= '1;
      msgBusy_q   <= 1'b0;
    end else begin
      vsMeta_q    <= bus.vs;
      vsSync_q    <= vsMeta_q;
      vsLast_q    <= vsSync_q;
      frameTick_q <= vsLast_q & ~vsSync_q;
      pendOpen_q  <= pendOpen_d;
      pendErr_q   <= pendErr_d;
      state_q     <= state_d;
      remain_q    <= remain_d;
      blinkCnt_q  <= blinkCnt_d;
      blinkOn_q   <= blinkOn_d;
      ssdLines_q  <= ssdLines_d;
      msgBusy_q   <= msgBusy_d;
    end
  end

  assign bus.ssd_lines = ssdLines_q;
  assign bus.msg_busy  = msgBusy_q;

endmodule
